// File: rtl/hb_freq_modulator_if.sv
// Command/gate bundle between the PI controller side and the bridge modulator.
interface hb_freq_modulator_if;
    logic               i_EN;
    logic signed [31:0] i_cmd;
    logic               o_GATE_H;
    logic               o_GATE_L;
    logic               o_SYNC;
    logic signed [31:0] o_aw;
    logic               o_SAT;

    // Controller side: drives enable and half-period command.
    modport master (
        output i_EN,
        output i_cmd,
        input  o_GATE_H,
        input  o_GATE_L,
        input  o_SYNC,
        input  o_aw,
        input  o_SAT
    );

    // Modulator side.
    modport slave (
        input  i_EN,
        input  i_cmd,
        output o_GATE_H,
        output o_GATE_L,
        output o_SYNC,
        output o_aw,
        output o_SAT
    );
endinterface

// File: rtl/hb_freq_modulator.sv
// Half-bridge gate generator: clamps the PI half-period command, latches it at each
// half-period boundary and drives a complementary gate pair with fixed dead time.
// The clamp excess is returned as the anti-windup term.
module hb_freq_modulator #(
    parameter int unsigned DT     = 10,
    parameter int unsigned HP_MIN = 50,
    parameter int unsigned HP_MAX = 500
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    hb_freq_modulator_if.slave bus
);

    localparam logic signed [31:0] HpMinS = 32'(HP_MIN);
    localparam logic signed [31:0] HpMaxS = 32'(HP_MAX);
    localparam logic [31:0]        DtLast = 32'(DT - 1);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StDtH  = 3'd1,
        StOnH  = 3'd2,
        StDtL  = 3'd3,
        StOnL  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        hp_q, hp_d;
    logic               sync_q, sync_d;
    logic signed [31:0] aw_q, aw_d;
    logic               sat_q, sat_d;

    logic signed [31:0] cmd_c;
    logic [31:0]        hp_last;

    // Clamp the command into the safe half-period window and form the excess.
    always_comb begin
        cmd_c = bus.i_cmd;
        if (bus.i_cmd > HpMaxS) begin
            cmd_c = HpMaxS;
        end else if (bus.i_cmd < HpMinS) begin
            cmd_c = HpMinS;
        end
        aw_d  = bus.i_cmd - cmd_c;
        sat_d = (aw_d != 32'sd0);
    end

    assign hp_last = hp_q - 32'd1;

    // Next-state logic: dead time then on time within each latched half-period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        hp_d    = hp_q;
        sync_d  = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.i_EN) begin
                    state_d = StDtH;
                    hp_d    = $unsigned(cmd_c);
                    sync_d  = 1'b1;
                end
            end
            StDtH: begin
                if (cnt_q == DtLast) begin
                    state_d = StOnH;
                end
            end
            StOnH: begin
                if (cnt_q == hp_last) begin
                    state_d = StDtL;
                    cnt_d   = '0;
                    hp_d    = $unsigned(cmd_c);
                end
            end
            StDtL: begin
                if (cnt_q == DtLast) begin
                    state_d = StOnL;
                end
            end
            StOnL: begin
                if (cnt_q == hp_last) begin
                    state_d = StDtH;
                    cnt_d   = '0;
                    hp_d    = $unsigned(cmd_c);
                    sync_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Disable wins over every boundary transition; the latched hp is kept.
        if ((state_q != StIdle) && !bus.i_EN) begin
            state_d = StIdle;
            cnt_d   = '0;
            hp_d    = hp_q;
            sync_d  = 1'b0;
        end
    end

    // State, counter, latched half-period and registered outputs.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hp_q    <= 32'(HP_MAX);
            sync_q  <= 1'b0;
            aw_q    <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            sync_q  <= sync_d;
            aw_q    <= aw_d;
            sat_q   <= sat_d;
        end
    end

    // Gates decode straight from the state register so async reset drops them at once.
    assign bus.o_GATE_H = (state_q == StOnH);
    assign bus.o_GATE_L = (state_q == StOnL);
    assign bus.o_SYNC   = sync_q;
    assign bus.o_aw     = aw_q;
    assign bus.o_SAT    = sat_q;

    // Shoot-through guard: the two gates must never be on together.
    always @(posedge i_CLK) begin
        if (i_RST) begin
            assert (!(bus.o_GATE_H && bus.o_GATE_L))
                else $error("gate overlap");
        end
    end

endmodule
